// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low {g,f,e,d,c,b,a} glyph constants and off patterns shared by seven-segment blocks.
package seg7_pkg;
   localparam logic [6:0] SEG_0   = 7'h40;
   localparam logic [6:0] SEG_1   = 7'h79;
   localparam logic [6:0] SEG_2   = 7'h24;
   localparam logic [6:0] SEG_3   = 7'h30;
   localparam logic [6:0] SEG_4   = 7'h19;
   localparam logic [6:0] SEG_5   = 7'h12;
   localparam logic [6:0] SEG_6   = 7'h02;
   localparam logic [6:0] SEG_7   = 7'h78;
   localparam logic [6:0] SEG_8   = 7'h00;
   localparam logic [6:0] SEG_9   = 7'h10;
   localparam logic [6:0] SEG_A   = 7'h08;
   localparam logic [6:0] SEG_B   = 7'h03;
   localparam logic [6:0] SEG_C   = 7'h46;
   localparam logic [6:0] SEG_D   = 7'h21;
   localparam logic [6:0] SEG_E   = 7'h06;
   localparam logic [6:0] SEG_F   = 7'h0E;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit source to display driver bundle; master is the digit source, slave the driver.
interface seg7_scan_driver_if;
   logic [15:0] digits_i;
   logic [3:0]  dp_i;
   logic [3:0]  blink_mask_i;
   logic        blank_i;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;
   logic        frame_o;
   modport master (output digits_i, dp_i, blink_mask_i, blank_i, input seg_o, dp_o, an_o, frame_o);
   modport slave  (input digits_i, dp_i, blink_mask_i, blank_i, output seg_o, dp_o, an_o, frame_o);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit nibble to active-low seven-segment hex glyph.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);
   always_comb begin
      case (nib_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         default: seg_o = SEG_F;
      endcase
   end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode scan with per-frame snapshot, dead-time guard,
// per-digit blink and global blank; all pins registered one cycle behind counter state.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 1000,
   parameter int BLINK_DIV   = 250
) (
   input logic               clk,
   input logic               arst_i,
   seg7_scan_driver_if.slave bus
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [CW-1:0] CNT_TERM   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD);
   localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_DIV - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic [15:0]   snap_dig_q, snap_dig_d;
   logic [3:0]    snap_dp_q, snap_dp_d, snap_mask_q, snap_mask_d;
   logic [6:0]    seg_q, seg_d, glyph;
   logic [3:0]    an_q, an_d;
   logic          dp_q, dp_d, frame_q, frame_d;
   logic          slot_tick, wrap, hide;
   seg7_hex_decode u_dec (.nib_i(snap_dig_q[{idx_q, 2'b00} +: 4]), .seg_o(glyph));
   always_comb begin
      slot_tick   = cnt_q == CNT_TERM;
      wrap        = slot_tick && idx_q == 2'd3;
      cnt_d       = slot_tick ? '0 : cnt_q + CW'(1);
      idx_d       = idx_q + 2'(slot_tick);
      bcnt_d      = !slot_tick ? bcnt_q : (bcnt_q == BLINK_TERM) ? '0 : bcnt_q + BW'(1);
      phase_d     = phase_q ^ (slot_tick && bcnt_q == BLINK_TERM);
      snap_dig_d  = wrap ? bus.digits_i : snap_dig_q;
      snap_dp_d   = wrap ? bus.dp_i : snap_dp_q;
      snap_mask_d = wrap ? bus.blink_mask_i : snap_mask_q;
      // guard runs off the counter state, so the anode registered at an index change is always off
      hide        = bus.blank_i || cnt_q < CNT_GUARD || (phase_q && snap_mask_q[idx_q]);
      an_d        = hide ? AN_OFF : ~(4'b0001 << idx_q);
      seg_d       = glyph;
      dp_d        = ~snap_dp_q[idx_q];
      frame_d     = wrap;
   end
   always_ff @(posedge clk or posedge arst_i) begin
      if (arst_i) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         bcnt_q      <= '0;
         phase_q     <= 1'b0;
         snap_dig_q  <= '0;
         snap_dp_q   <= '0;
         snap_mask_q <= '0;
         seg_q       <= SEG_OFF;
         an_q        <= AN_OFF;
         dp_q        <= 1'b1;
         frame_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         bcnt_q      <= bcnt_d;
         phase_q     <= phase_d;
         snap_dig_q  <= snap_dig_d;
         snap_dp_q   <= snap_dp_d;
         snap_mask_q <= snap_mask_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         dp_q        <= dp_d;
         frame_q     <= frame_d;
      end
   end
   assign bus.seg_o   = seg_q;
   assign bus.an_o    = an_q;
   assign bus.dp_o    = dp_q;
   assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, guard, snapshot, blink, blank and async reset
// with REFRESH_DIV=8, GUARD=2, BLINK_DIV=2.
module tb_seg7_scan_driver;
   logic clk = 1'b0;
   logic arst_i = 1'b1;
   int   nvec = 0;
   int   nerr = 0;
   int   blank_rem = 0;
   bit   blank_seen;
   seg7_scan_driver_if bus ();
   seg7_scan_driver #(.REFRESH_DIV(8), .GUARD(2), .BLINK_DIV(2)) dut (
      .clk(clk), .arst_i(arst_i), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic chk_dark(input string tag);
      chk({tag, " an"}, {4'h0, bus.an_o}, 8'h0F);
      chk({tag, " seg"}, {1'b0, bus.seg_o}, 8'h7F);
      chk({tag, " dp"}, {7'h0, bus.dp_o}, 8'h01);
      chk({tag, " frame"}, {7'h0, bus.frame_o}, 8'h00);
   endtask
   // One 8-cycle slot for digit d: 2 dark guard cycles then the anode; frame_o on the last cycle of digit 3.
   task automatic run_slot(input int d, input logic [6:0] seg, input bit dpb, input bit hid, input int blank_at);
      logic [3:0] on;
      on = ~(4'b0001 << d);
      for (int c = 1; c <= 8; c++) begin
         blank_seen = bus.blank_i;
         @(negedge clk);
         chk($sformatf("an d%0d c%0d", d, c), {4'h0, bus.an_o},
             {4'h0, (c <= 2 || hid || blank_seen) ? 4'hF : on});
         chk($sformatf("seg d%0d c%0d", d, c), {1'b0, bus.seg_o}, {1'b0, seg});
         chk($sformatf("dp d%0d c%0d", d, c), {7'h0, bus.dp_o}, {7'h0, ~dpb});
         chk($sformatf("frame d%0d c%0d", d, c), {7'h0, bus.frame_o}, {7'h0, d == 3 && c == 8});
         chk($sformatf("onehot d%0d c%0d", d, c), {7'h0, $onehot0(~bus.an_o)}, 8'h01);
         if (c == blank_at) blank_rem = 20;
         if (blank_rem > 0) begin
            bus.blank_i = 1'b1;
            blank_rem--;
         end else bus.blank_i = 1'b0;
      end
   endtask
   initial begin
      bus.digits_i = 16'h1234;
      bus.dp_i = 4'h0;
      bus.blink_mask_i = 4'h0;
      bus.blank_i = 1'b0;
      @(negedge clk);
      chk_dark("reset");
      @(negedge clk);
      arst_i = 1'b0;
      // first frame shows the cleared snapshot: zeros
      for (int d = 0; d < 4; d++) run_slot(d, 7'h40, 1'b0, 1'b0, 0);
      // frame with 1234; inputs change to 5678 while digit 2 is up
      run_slot(0, 7'h19, 1'b0, 1'b0, 0);
      run_slot(1, 7'h30, 1'b0, 1'b0, 0);
      bus.digits_i = 16'h5678;
      run_slot(2, 7'h24, 1'b0, 1'b0, 0);
      run_slot(3, 7'h79, 1'b0, 1'b0, 0);
      // frame with 5678; blink mask and dp requests change mid-frame
      run_slot(0, 7'h00, 1'b0, 1'b0, 0);
      bus.blink_mask_i = 4'b0101;
      bus.dp_i = 4'b0010;
      run_slot(1, 7'h78, 1'b0, 1'b0, 0);
      run_slot(2, 7'h02, 1'b0, 1'b0, 0);
      run_slot(3, 7'h12, 1'b0, 1'b0, 0);
      // slots 12..15 since reset: phase is 0 for slots 12,13 and 1 for 14,15, so digit 0 shows, digit 2 hides
      run_slot(0, 7'h00, 1'b0, 1'b0, 0);
      bus.blink_mask_i = 4'b0000;
      bus.digits_i = 16'hCDEF;
      run_slot(1, 7'h78, 1'b1, 1'b0, 0);
      run_slot(2, 7'h02, 1'b0, 1'b1, 0);
      run_slot(3, 7'h12, 1'b0, 1'b0, 0);
      // CDEF frame with a 20-cycle blank starting mid digit 1
      run_slot(0, 7'h0E, 1'b0, 1'b0, 0);
      run_slot(1, 7'h06, 1'b1, 1'b0, 4);
      run_slot(2, 7'h21, 1'b0, 1'b0, 0);
      run_slot(3, 7'h46, 1'b0, 1'b0, 0);
      // scan resumes in place, then async reset mid digit 1
      run_slot(0, 7'h0E, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      arst_i = 1'b1;
      #1;
      chk_dark("async reset");
      @(negedge clk);
      chk_dark("reset held");
      arst_i = 1'b0;
      for (int d = 0; d < 4; d++) run_slot(d, 7'h40, 1'b0, 1'b0, 0);
      run_slot(0, 7'h0E, 1'b0, 1'b0, 0);
      run_slot(1, 7'h06, 1'b1, 1'b0, 0);
      run_slot(2, 7'h21, 1'b0, 1'b0, 0);
      run_slot(3, 7'h46, 1'b0, 1'b0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
